// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the front-panel DAC value controller.
//   - bcd_state_e : converter FSM states (idle / shifting)
//   - STEP_FINE / STEP_COARSE : step sizes selected by step_sel
//   - VAL_MAX : upper clamp for the 8-bit DAC code
//   - add3 : double-dabble digit correction
package dac_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } bcd_state_e;

   localparam logic [7:0] STEP_FINE   = 8'd1;
   localparam logic [7:0] STEP_COARSE = 8'd10;
   localparam logic [8:0] VAL_MAX     = 9'd255;

   // Add 3 to a BCD nibble that is 5 or more so the following shift carries correctly.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stability counter for one raw push button.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   btn_raw - raw button level, asynchronous to clk
//   level   - debounced level; flips after DB_CNT consecutive differing synced cycles
module btn_debounce #(
   parameter int unsigned DB_CNT = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level
);

   localparam int unsigned CW = (DB_CNT < 2) ? 1 : $clog2(DB_CNT + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b00;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_raw};
         if (sync_q[1] == level_q) begin
            // Any agreeing cycle restarts the stability window.
            cnt_q <= '0;
         end else if (cnt_q == CW'(DB_CNT - 1)) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level = level_q;

endmodule

// File: rtl/dac_val_ctrl.sv
// dac_val_ctrl: debounces up/down/clear buttons, keeps a saturating 8-bit DAC code and
// converts it to three BCD digits with a sequential double-dabble engine.
// Optional feature: define DAC_VAL_AUTOREPEAT_EN to enable hold-to-repeat on up/down.
// Ports:
//   clk, rst                - system clock, asynchronous active-high reset
//   btn_up, btn_dn, btn_clr - raw active-high buttons
//   step_sel                - 0: step 1, 1: step 10
//   val, val_upd            - current DAC code and one-cycle update pulse
//   bcd_h, bcd_t, bcd_o     - digits of the last converted value
//   bcd_valid               - digits match the current val
module dac_val_ctrl #(
   parameter int unsigned DB_CNT   = 50000,
   parameter int unsigned RPT_DLY  = 500000,
   parameter int unsigned RPT_RATE = 100000,
   parameter logic [7:0]  RST_VAL  = 8'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_dn,
   input  logic       btn_clr,
   input  logic       step_sel,
   output logic [7:0] val,
   output logic       val_upd,
   output logic [3:0] bcd_h,
   output logic [3:0] bcd_t,
   output logic [3:0] bcd_o,
   output logic       bcd_valid
);

   import dac_pkg::*;

   // ---------------------------------------------------------------- debounce and edges
   logic up_db, dn_db, clr_db;
   logic up_db_q, dn_db_q, clr_db_q;

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_up (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_up),
      .level   (up_db)
   );

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_dn (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_dn),
      .level   (dn_db)
   );

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_clr (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clr),
      .level   (clr_db)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_db_q  <= 1'b0;
         dn_db_q  <= 1'b0;
         clr_db_q <= 1'b0;
      end else begin
         up_db_q  <= up_db;
         dn_db_q  <= dn_db;
         clr_db_q <= clr_db;
      end
   end

   logic up_ev, dn_ev, clr_ev;
   assign up_ev  = up_db & ~up_db_q;
   assign dn_ev  = dn_db & ~dn_db_q;
   assign clr_ev = clr_db & ~clr_db_q;

   logic up_step, dn_step;

`ifdef DAC_VAL_AUTOREPEAT_EN
   // ---------------------------------------------------------------- auto-repeat
   localparam int unsigned HW = (RPT_DLY < 2) ? 1 : $clog2(RPT_DLY + 1);
   localparam int unsigned RW = (RPT_RATE < 2) ? 1 : $clog2(RPT_RATE + 1);

   logic [HW-1:0] hold_q;
   logic [RW-1:0] rate_q;
   logic          hold_active;
   logic          rpt_fire;

   // Only one direction held counts; both held or none held rewinds the counters.
   assign hold_active = up_db ^ dn_db;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
         rate_q <= '0;
      end else if (!hold_active) begin
         hold_q <= '0;
         rate_q <= '0;
      end else if (hold_q != HW'(RPT_DLY)) begin
         hold_q <= hold_q + 1'b1;
      end else begin
         rate_q <= (rate_q == RW'(RPT_RATE - 1)) ? '0 : rate_q + 1'b1;
      end
   end

   assign rpt_fire = hold_active && (hold_q == HW'(RPT_DLY)) && (rate_q == '0);
   assign up_step  = up_ev | (rpt_fire & up_db);
   assign dn_step  = dn_ev | (rpt_fire & dn_db);
`else
   logic unused_rpt_cfg;
   assign unused_rpt_cfg = (RPT_DLY != 0) ^ (RPT_RATE != 0);
   assign up_step = up_ev;
   assign dn_step = dn_ev;
`endif

   // ---------------------------------------------------------------- value register
   logic [7:0] val_q, val_d;
   logic       val_upd_q, val_upd_d;
   logic [8:0] step9, sum9, diff9;

   assign step9 = {1'b0, (step_sel ? STEP_COARSE : STEP_FINE)};
   assign sum9  = {1'b0, val_q} + step9;
   assign diff9 = {1'b0, val_q} - step9;

   always_comb begin
      val_d     = val_q;
      val_upd_d = 1'b0;
      if (clr_ev) begin
         // Clear always reports an update, even when the value does not move.
         val_d     = RST_VAL;
         val_upd_d = 1'b1;
      end else if (up_step && !dn_step) begin
         val_d     = (sum9 > VAL_MAX) ? VAL_MAX[7:0] : sum9[7:0];
         val_upd_d = (val_d != val_q);
      end else if (dn_step && !up_step) begin
         val_d     = diff9[8] ? 8'd0 : diff9[7:0];
         val_upd_d = (val_d != val_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q     <= RST_VAL;
         val_upd_q <= 1'b0;
      end else begin
         val_q     <= val_d;
         val_upd_q <= val_upd_d;
      end
   end

   // ---------------------------------------------------------------- BCD converter
   bcd_state_e  state_q, state_d;
   logic [2:0]  iter_q, iter_d;
   logic [19:0] sh_q, sh_d;         // {hundreds, tens, ones, binary}
   logic [11:0] bcd_q, bcd_d;
   logic        valid_q, valid_d;
   logic        pending_q, pending_d;
   logic [19:0] sh_adj, sh_next;

   assign sh_adj  = {add3(sh_q[19:16]), add3(sh_q[15:12]), add3(sh_q[11:8]), sh_q[7:0]};
   assign sh_next = {sh_adj[18:0], 1'b0};

   always_comb begin
      state_d   = state_q;
      iter_d    = iter_q;
      sh_d      = sh_q;
      bcd_d     = bcd_q;
      valid_d   = valid_q;
      pending_d = pending_q;
      if (val_upd_q || pending_q) begin
         // A new value restarts the conversion even mid-shift.
         state_d   = StShift;
         iter_d    = 3'd0;
         sh_d      = {12'd0, val_q};
         valid_d   = 1'b0;
         pending_d = 1'b0;
      end else if (state_q == StShift) begin
         sh_d   = sh_next;
         iter_d = iter_q + 3'd1;
         if (iter_q == 3'd7) begin
            bcd_d   = sh_next[19:8];
            valid_d = 1'b1;
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         iter_q    <= 3'd0;
         sh_q      <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
         pending_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         iter_q    <= iter_d;
         sh_q      <= sh_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
         pending_q <= pending_d;
      end
   end

   assign val       = val_q;
   assign val_upd   = val_upd_q;
   assign bcd_h     = bcd_q[11:8];
   assign bcd_t     = bcd_q[7:4];
   assign bcd_o     = bcd_q[3:0];
   assign bcd_valid = valid_q;

endmodule

// File: tb/tb_dac_val_ctrl.sv
// tb_dac_val_ctrl: directed and randomized checks of dac_val_ctrl against a value/digit model.
// Honours DAC_VAL_AUTOREPEAT_EN when building the expected step sequence for held buttons.
module tb_dac_val_ctrl;

   localparam int DB   = 4;
   localparam int DLY  = 20;
   localparam int RATE = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0, btn_dn = 1'b0, btn_clr = 1'b0, step_sel = 1'b0;
   logic [7:0] val;
   logic       val_upd;
   logic [3:0] bcd_h, bcd_t, bcd_o;
   logic       bcd_valid;

   int errors = 0;
   int checks = 0;
   int model_val = 0;

   always #5 clk = ~clk;

   dac_val_ctrl #(
      .DB_CNT   (DB),
      .RPT_DLY  (DLY),
      .RPT_RATE (RATE),
      .RST_VAL  (8'd0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_dn    (btn_dn),
      .btn_clr   (btn_clr),
      .step_sel  (step_sel),
      .val       (val),
      .val_upd   (val_upd),
      .bcd_h     (bcd_h),
      .bcd_t     (bcd_t),
      .bcd_o     (bcd_o),
      .bcd_valid (bcd_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] digits_of(input int v);
      logic [31:0] d;
      d = 32'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
      return d;
   endfunction

   function automatic logic [31:0] digits_dut();
      return {20'd0, bcd_h, bcd_t, bcd_o};
   endfunction

   // Value rules: clear wins, up+down cancel, otherwise saturating step.
   function automatic int model_next(input int v, input bit u, input bit d, input bit c,
                                     input bit s);
      int st;
      st = s ? 10 : 1;
      if (c) return 0;
      if (u && d) return v;
      if (u) return (v + st > 255) ? 255 : v + st;
      if (d) return (v - st < 0) ? 0 : v - st;
      return v;
   endfunction

   task automatic do_reset(input string tag);
      rst = 1'b1;
      btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0; step_sel = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_rst_val"}, 32'(val), 0);
      check({tag, "_rst_upd"}, 32'(val_upd), 0);
      check({tag, "_rst_bcd"}, digits_dut(), 0);
      check({tag, "_rst_valid"}, 32'(bcd_valid), 0);
      rst = 1'b0;
      model_val = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 8) check({tag, "_valid_pre"}, 32'(bcd_valid), 0);
      end
      check({tag, "_valid_9"}, 32'(bcd_valid), 1);
      check({tag, "_bcd_init"}, digits_dut(), digits_of(0));
   endtask

   // Hold the given buttons for 'hold' cycles, then observe pulses and final state.
   task automatic press(input bit u, input bit d, input bit c, input bit s, input int hold,
                        input string tag);
      int  nv, exp_pulses, pulses, first_i;
      bit  first_upd;
      exp_pulses = 0;
      pulses     = 0;
      first_i    = -1;
      nv         = model_next(model_val, u, d, c, s);
      first_upd  = c || (nv != model_val);
      if (first_upd) exp_pulses++;
      model_val = nv;
`ifdef DAC_VAL_AUTOREPEAT_EN
      if (u ^ d) begin
         for (int k = DLY; k < hold; k += RATE) begin
            nv = model_next(model_val, u, d, 1'b0, s);
            if (nv != model_val) exp_pulses++;
            model_val = nv;
         end
      end
`endif
      @(negedge clk);
      step_sel = s;
      btn_up = u; btn_dn = d; btn_clr = c;
      for (int i = 1; i <= hold + 24; i++) begin
         @(negedge clk);
         if (val_upd === 1'b1) begin
            pulses++;
            if (first_i < 0) first_i = i;
         end
         if (i == hold) begin
            btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
         end
      end
      check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
      if (first_upd) check({tag, "_latency"}, 32'(first_i), 32'(DB + 3));
      check({tag, "_val"}, 32'(val), 32'(model_val));
      check({tag, "_bcd"}, digits_dut(), digits_of(model_val));
      check({tag, "_valid"}, 32'(bcd_valid), 1);
   endtask

   initial begin
      int pulses;
      int r;

      // Reset and first conversion of the reset value
      do_reset("init");

      // Glitches of 2 cycles never survive debounce
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         btn_up = 1'b1;
         repeat (2) begin @(negedge clk); if (val_upd === 1'b1) pulses++; end
         btn_up = 1'b0;
         repeat (2) begin @(negedge clk); if (val_upd === 1'b1) pulses++; end
      end
      repeat (20) begin @(negedge clk); if (val_upd === 1'b1) pulses++; end
      check("glitch_pulses", 32'(pulses), 0);
      check("glitch_val", 32'(val), 0);

      // Clean press: one step of 1
      press(1'b1, 1'b0, 1'b0, 1'b0, 10, "clean_up");

      // Saturation with coarse steps
      press(1'b0, 1'b0, 1'b1, 1'b0, 6, "clr0");
      for (int k = 0; k < 26; k++) press(1'b1, 1'b0, 1'b0, 1'b1, 6, "sat_up");
      check("sat_top", 32'(val), 255);
      press(1'b1, 1'b0, 1'b0, 1'b1, 6, "sat_extra");

      // Cancel and coarse down from 5
      press(1'b0, 1'b0, 1'b1, 1'b0, 6, "clr1");
      for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 1'b0, 1'b0, 6, "fine_up");
      press(1'b1, 1'b1, 1'b0, 1'b0, 6, "cancel");
      press(1'b0, 1'b1, 1'b0, 1'b1, 6, "dn_floor");
      check("dn_floor_zero", 32'(val), 0);

      // Clear beats up at 123
      for (int k = 0; k < 12; k++) press(1'b1, 1'b0, 1'b0, 1'b1, 6, "to123c");
      for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b0, 1'b0, 6, "to123f");
      check("at123", 32'(val), 123);
      press(1'b1, 1'b0, 1'b1, 1'b0, 6, "clr_up");

      // Long hold: one step, or auto-repeat steps when enabled
      press(1'b1, 1'b0, 1'b0, 1'b0, 50, "hold");

      // Conversion restart: 209 -> 199 (coarse down) then 200 (fine up) 3 cycles later
      press(1'b0, 1'b0, 1'b1, 1'b0, 6, "clr2");
      for (int k = 0; k < 20; k++) press(1'b1, 1'b0, 1'b0, 1'b1, 6, "to209c");
      for (int k = 0; k < 9; k++) press(1'b1, 1'b0, 1'b0, 1'b0, 6, "to209f");
      check("at209", 32'(val), 209);
      @(negedge clk);
      step_sel = 1'b1;
      btn_dn = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 3) btn_up = 1'b1;
         if (i == 7) begin
            check("rs_first_val", 32'(val), 199);
            check("rs_first_upd", 32'(val_upd), 1);
         end
         if (i == 8) step_sel = 1'b0;
         if (i == 10) begin
            check("rs_second_val", 32'(val), 200);
            check("rs_second_upd", 32'(val_upd), 1);
         end
         if (i == 14) begin btn_up = 1'b0; btn_dn = 1'b0; end
         if (i == 16 || i == 18) begin
            check("rs_old_bcd", digits_dut(), digits_of(209));
            check("rs_not_valid", 32'(bcd_valid), 0);
         end
         if (i == 19) begin
            check("rs_new_bcd", digits_dut(), digits_of(200));
            check("rs_valid", 32'(bcd_valid), 1);
         end
      end
      model_val = 200;

      // Randomized presses against the model
      for (int k = 0; k < 30; k++) begin
         r = int'($urandom_range(0, 5));
         case (r)
            0, 1: press(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                        int'($urandom_range(5, 12)), "rnd_up");
            2, 3: press(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
                        int'($urandom_range(5, 12)), "rnd_dn");
            4:    press(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)),
                        int'($urandom_range(5, 12)), "rnd_clr");
            default: press(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
                           int'($urandom_range(5, 12)), "rnd_both");
         endcase
      end

      // Reset in the middle of a conversion
      @(negedge clk);
      btn_up = 1'b1;
      repeat (9) @(negedge clk);
      do_reset("midrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
